uart_pkt_parser: RTL
====================

Name: uart_pkt_parser

Overview:
- Sits directly downstream of the UART byte receiver and consumes its byte/valid output.
- Frames the byte stream into packets of the form SOF, LEN, payload, CHK.
- Buffers the payload and checks an XOR checksum.
- Streams verified payload bytes to the command layer over a valid/ready interface; failed packets are reported, never emitted.

Parameters:
- SOF_BYTE, 8'hA5: start-of-frame marker.
- MAX_LEN, 16: maximum payload length in bytes; must be 1..255.
- TIMEOUT_CYC, 40000: inter-byte timeout in clk cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  level-style valid from the receiver; a new byte is its rising edge.
- rx_ack  out  1  one-cycle pulse per accepted byte; drives the receiver's soft_reset.
- pkt_data  out  8  payload byte.
- pkt_valid  out  1  pkt_data is valid.
- pkt_ready  in  1  downstream accepts the byte.
- pkt_last  out  1  marks the final payload byte; qualified by pkt_valid.
- pkt_len  out  8  length of the packet currently being emitted; stable while in EMIT.
- pkt_err  out  1  one-cycle pulse on a failed packet.
- err_code  out  2  01 bad length, 10 checksum, 11 timeout; held until the next error.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, buffer index 0, checksum accumulator 0.
- Byte strobe:
  - rx_valid is registered once.
  - A byte event is rx_valid=1 while the registered copy is 0.
  - rx_data is sampled in the same cycle as the event.
  - rx_ack pulses in the cycle after every byte event, in any state.
- FSM states:
  - IDLE: on a byte event equal to SOF_BYTE, go to LEN; other bytes are discarded silently.
  - LEN:
    - byte 0 or byte > MAX_LEN: pkt_err pulse, err_code=01, go to IDLE.
    - otherwise: latch len, chk=byte, idx=0, go to PAYLOAD.
  - PAYLOAD: each byte event writes buf[idx] and XORs the byte into chk.
    - idx increments.
    - When idx reaches len-1 with a write, go to CHK.
  - CHK:
    - byte == chk: go to EMIT, idx=0.
    - byte != chk: pkt_err pulse, err_code=10, go to IDLE.
  - EMIT:
    - pkt_valid=1, pkt_data=buf[idx], pkt_last=(idx==len-1).
    - On pkt_valid && pkt_ready, idx increments.
    - After the last transfer, pkt_valid drops the next cycle and the FSM goes to IDLE.
- Stream rules: pkt_data, pkt_last and pkt_valid are registered and must hold stable while pkt_valid=1 and pkt_ready=0. Throughput is one byte per cycle when pkt_ready is held high.
- Latency: the first pkt_valid rises 2 cycles after the CHK byte event.
- Bytes arriving during EMIT are acked and dropped; FSM and buffer are unaffected. Senders must gap packets.
- A SOF byte seen in LEN, PAYLOAD or CHK is treated as data; there is no resynchronisation except through error or timeout.
- Reset asserted mid-packet or mid-EMIT: immediate return to IDLE, pkt_valid=0; no partial packet is resumed.
- Buffer: MAX_LEN x 8 register array, no reset required on the contents.

Optional Feature:
- Macro: UART_PKT_TIMEOUT_EN.
- When defined:
  - A counter resets on every byte event and runs only in LEN, PAYLOAD and CHK.
  - Reaching TIMEOUT_CYC-1 gives: pkt_err pulse, err_code=11, FSM to IDLE, counter to 0.
  - A byte event in the same cycle as expiry wins, and no timeout is raised.
- When undefined: no counter logic is built, err_code 11 never occurs, and a stalled packet waits indefinitely.

Decomposition:
- Package uart_pkt_pkg holds:
  - state enum: IDLE, LEN, PAYLOAD, CHK, EMIT.
  - err_code constants: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT.
  - the default SOF constant.
- Sub-module uart_byte_strobe: rising-edge detector on rx_valid, plus the rx_data sample and the rx_ack pulse generator. It is reusable by other UART consumers.

Test Plan:
- Good packet: A5,03,11,22,33,CHK=03^11^22^33=03 with pkt_ready=1 -> pkt_data 11,22,33 on consecutive cycles; pkt_last only on 33; pkt_len=3; no pkt_err.
- Backpressure: same packet with pkt_ready toggled 0/1 every cycle -> bytes are never duplicated or skipped; pkt_data stays stable while stalled.
- Errors:
  - A5,00 -> pkt_err, err_code=01.
  - A5,11 with MAX_LEN=16 -> pkt_err, err_code=01.
  - A5,02,AA,BB,00 -> pkt_err, err_code=10; no pkt_valid.
- Noise then frame: 00,FF,A5,01,7E,7F -> the garbage is dropped, one payload byte 7E is emitted, and rx_ack pulses 6 times.
- Reset mid-EMIT: assert rst during the second payload byte -> pkt_valid=0 immediately; the next valid packet parses normally.
- With UART_PKT_TIMEOUT_EN and TIMEOUT_CYC=100: A5,04,01 followed by silence -> pkt_err with err_code=11, 100 cycles after the last byte event, then the FSM accepts a new SOF.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CHK,
      EMIT
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's level-style valid into a single-cycle byte event,
// and acks each accepted byte one cycle later.
module uart_byte_strobe (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       byte_evt_o,
   output logic [7:0] byte_o,
   output logic       rx_ack_o
);

   logic rx_valid_q;
   logic rx_ack_q;

   assign byte_evt_o = rx_valid_i & ~rx_valid_q;
   assign byte_o     = rx_data_i;
   assign rx_ack_o   = rx_ack_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid_q <= 1'b0;
         rx_ack_q   <= 1'b0;
      end else begin
         rx_valid_q <= rx_valid_i;
         rx_ack_q   <= byte_evt_o;
      end
   end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames SOF/LEN/payload/CHK packets, verifies XOR checksum, streams payload.
// Optional inter-byte timeout is built when UART_PKT_TIMEOUT_EN is defined.
//   state   | meaning
//   IDLE    | hunting for SOF
//   LEN     | waiting for length byte
//   PAYLOAD | buffering payload bytes
//   CHK     | waiting for checksum byte
//   EMIT    | streaming buffered payload downstream
module uart_pkt_parser
   import uart_pkt_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 40000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       rx_ack_o,
   output logic [7:0] pkt_data_o,
   output logic       pkt_valid_o,
   input  logic       pkt_ready_i,
   output logic       pkt_last_o,
   output logic [7:0] pkt_len_o,
   output logic       pkt_err_o,
   output logic [1:0] err_code_o
);

   localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   logic          evt;
   logic [7:0]    rx_byte;
   logic          tmo_fire;

   state_e        state_q;
   logic [7:0]    len_q;
   logic [7:0]    chk_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_inc_d;
   logic [7:0]    mem_q [MAX_LEN];
   logic [7:0]    pkt_data_q;
   logic          pkt_valid_q;
   logic          pkt_last_q;
   logic          pkt_err_q;
   logic [1:0]    err_code_q;

   uart_byte_strobe u_strobe (
      .clk        (clk),
      .rst        (rst),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .byte_evt_o (evt),
      .byte_o     (rx_byte),
      .rx_ack_o   (rx_ack_o)
   );

   assign idx_inc_d = idx_q + 1'b1;

`ifdef UART_PKT_TIMEOUT_EN
   logic [31:0] tmo_q;
   logic        in_pkt;

   assign in_pkt   = state_q inside {LEN, PAYLOAD, CHK};
   // A byte in the expiry cycle wins over the timeout.
   assign tmo_fire = in_pkt && !evt && (tmo_q == 32'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else if (!in_pkt || evt || tmo_fire) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 32'd1;
      end
   end
`else
   assign tmo_fire = 1'b0;
   if (TIMEOUT_CYC < 1) begin : g_tmo_unused
   end
`endif

   // Payload buffer has no reset; contents are only read after being written.
   always_ff @(posedge clk) begin
      if (state_q == PAYLOAD && evt) begin
         mem_q[idx_q] <= rx_byte;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         chk_q       <= '0;
         idx_q       <= '0;
         pkt_data_q  <= '0;
         pkt_valid_q <= 1'b0;
         pkt_last_q  <= 1'b0;
         pkt_err_q   <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         pkt_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (evt && rx_byte == SOF_BYTE) state_q <= LEN;
            end
            LEN: begin
               if (evt) begin
                  if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= ERR_LEN;
                     state_q    <= IDLE;
                  end else begin
                     len_q   <= rx_byte;
                     chk_q   <= rx_byte;
                     idx_q   <= '0;
                     state_q <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (evt) begin
                  chk_q <= chk_q ^ rx_byte;
                  idx_q <= idx_inc_d;
                  if (8'(idx_q) == len_q - 8'd1) state_q <= CHK;
               end
            end
            CHK: begin
               if (evt) begin
                  if (rx_byte == chk_q) begin
                     idx_q   <= '0;
                     state_q <= EMIT;
                  end else begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= ERR_CHK;
                     state_q    <= IDLE;
                  end
               end
            end
            EMIT: begin
               // idx_q always points at the byte currently presented.
               if (!pkt_valid_q) begin
                  pkt_valid_q <= 1'b1;
                  pkt_data_q  <= mem_q[idx_q];
                  pkt_last_q  <= (8'(idx_q) == len_q - 8'd1);
               end else if (pkt_ready_i) begin
                  if (pkt_last_q) begin
                     pkt_valid_q <= 1'b0;
                     pkt_last_q  <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     idx_q      <= idx_inc_d;
                     pkt_data_q <= mem_q[idx_inc_d];
                     pkt_last_q <= (8'(idx_inc_d) == len_q - 8'd1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         if (tmo_fire) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= IDLE;
         end
      end
   end

   assign pkt_data_o  = pkt_data_q;
   assign pkt_valid_o = pkt_valid_q;
   assign pkt_last_o  = pkt_last_q;
   assign pkt_len_o   = len_q;
   assign pkt_err_o   = pkt_err_q;
   assign err_code_o  = err_code_q;

endmodule
